// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the multicycle instruction fetch front-end.
package instr_fetch_unit_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Memory beats per instruction; IWIDTH is expected to be a whole multiple of WIDTH.
  function automatic int unsigned beats_of(input int unsigned iwidth, input int unsigned width);
    return iwidth / width;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory-port and instruction-consumer bus of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned AWIDTH = 8
);
  logic              mem_req;
  logic [AWIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;
  logic              redirect;
  logic [AWIDTH-1:0] redirect_pc;
  logic              instr_valid;
  logic [IWIDTH-1:0] instr;
  logic [AWIDTH-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_rdata, mem_ack, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_rdata, mem_ack, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Circular prefetch FIFO with flush; head entry is presented from storage registers.
module instr_fetch_unit_queue #(
  parameter  int unsigned DATA_W = 40,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CW-1:0]     o_count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     r_wptr;
  logic [CW-1:0]     r_count;
  logic              r_valid;

  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign w_pop       = i_pop & (r_count != '0);
  assign w_push      = i_push & ((r_count != CW'(DEPTH)) | w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: assembles IWIDTH-bit words from WIDTH-bit beats into a prefetch queue.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       IWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 8,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned BEATS  = beats_of(IWIDTH, WIDTH);
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DATA_W = IWIDTH + AWIDTH;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  fetch_state_t      r_state;
  logic [AWIDTH-1:0] r_fpc;
  logic [BW-1:0]     r_beat;
  logic [IWIDTH-1:0] r_asm;
  logic              r_mem_req;
  logic [AWIDTH-1:0] r_mem_addr;

  fetch_state_t      w_nxt_state;
  logic [AWIDTH-1:0] w_nxt_fpc;
  logic [BW-1:0]     w_nxt_beat;
  logic [IWIDTH-1:0] w_asm;
  logic              w_ack;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_space;
  logic [CW:0]       w_cnt_after;
  logic [DATA_W-1:0] w_q_data;
  logic              w_q_valid;
  logic [CW-1:0]     w_q_count;

  // A redirect discards any beat completing in the same cycle and any pop.
  assign w_ack       = r_mem_req & bus.mem_ack & ~bus.redirect;
  assign w_last      = w_ack & (r_beat == BW'(BEATS - 1));
  assign w_push      = w_last;
  assign w_pop       = w_q_valid & bus.instr_ready & ~bus.redirect;
  assign w_cnt_after = (CW+1)'(w_q_count) + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_space     = (w_cnt_after < (CW+1)'(DEPTH));

  always_comb begin
    w_asm = r_asm;
    if (w_ack) begin
      for (int k = 0; k < BEATS; k++) begin
        if (r_beat == BW'(k)) w_asm[k*WIDTH +: WIDTH] = bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_fpc   = r_fpc;
    w_nxt_beat  = r_beat;
    if (bus.redirect) begin
      w_nxt_state = FETCH;
      w_nxt_fpc   = bus.redirect_pc;
      w_nxt_beat  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_space) w_nxt_state = FETCH;
        end
        FETCH: begin
          if (w_last) begin
            w_nxt_fpc   = r_fpc + AWIDTH'(BEATS);
            w_nxt_beat  = '0;
            w_nxt_state = w_space ? FETCH : IDLE;
          end else if (w_ack) begin
            w_nxt_beat = r_beat + BW'(1);
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  // State plus registered memory-port outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fpc      <= RESET_PC;
      r_beat     <= '0;
      r_asm      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_nxt_state;
      r_fpc      <= w_nxt_fpc;
      r_beat     <= w_nxt_beat;
      r_asm      <= bus.redirect ? '0 : w_asm;
      r_mem_req  <= (w_nxt_state == FETCH);
      r_mem_addr <= w_nxt_fpc + AWIDTH'(w_nxt_beat);
    end
  end

  instr_fetch_unit_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_fpc, w_asm}),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_data  (w_q_data),
    .o_valid (w_q_valid),
    .o_count (w_q_count)
  );

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = w_q_valid;
  assign bus.instr       = w_q_data[IWIDTH-1:0];
  assign bus.instr_pc    = w_q_data[DATA_W-1 -: AWIDTH];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus wait-state, redirect, wrap and reset sequences.
module tb_instr_fetch_unit;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  instr_fetch_unit_if #(.WIDTH(8), .IWIDTH(32), .AWIDTH(8)) bus ();

  instr_fetch_unit #(
    .WIDTH    (8),
    .IWIDTH   (32),
    .AWIDTH   (8),
    .DEPTH    (2),
    .RESET_PC (8'h10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        ack;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [7:0] memf(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h96;
  endfunction

  function automatic logic [31:0] instr_at(input logic [7:0] p);
    logic [7:0] p1, p2, p3;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    p3 = p + 8'd3;
    return {memf(p3), memf(p2), memf(p1), memf(p)};
  endfunction

  function automatic vec_t mk(input logic rdy, input logic ack, input logic req, input logic [7:0] addr,
                              input logic vld, input logic [7:0] pc);
    vec_t v;
    v.ready   = rdy;
    v.ack     = ack;
    v.e_req   = req;
    v.e_addr  = addr;
    v.e_valid = vld;
    v.e_pc    = pc;
    v.e_instr = instr_at(pc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle (memory returns the byte at the current address), then sample after the edge.
  task automatic step(input logic rdy, input logic ack, input logic redir, input logic [7:0] rpc);
    bus.instr_ready = rdy;
    bus.mem_ack     = ack;
    bus.mem_rdata   = memf(bus.mem_addr);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.instr_ready = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   32'(bus.mem_req),     32'd0);
    chk({tag, " addr"},  32'(bus.mem_addr),    32'h10);
    chk({tag, " valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, " instr"}, bus.instr,            32'd0);
    chk({tag, " pc"},    32'(bus.instr_pc),    32'd0);
  endtask

  initial begin
    int         nacks;
    int         cyc;
    logic       pre_req;
    logic       ack;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;

    tbl[0]  = mk(0, 1, 1, 8'h10, 0, 8'h00);
    tbl[1]  = mk(0, 1, 1, 8'h11, 0, 8'h00);
    tbl[2]  = mk(0, 1, 1, 8'h12, 0, 8'h00);
    tbl[3]  = mk(0, 1, 1, 8'h13, 0, 8'h00);
    tbl[4]  = mk(0, 1, 1, 8'h14, 1, 8'h10);
    tbl[5]  = mk(0, 1, 1, 8'h15, 1, 8'h10);
    tbl[6]  = mk(0, 1, 1, 8'h16, 1, 8'h10);
    tbl[7]  = mk(0, 1, 1, 8'h17, 1, 8'h10);
    tbl[8]  = mk(0, 1, 0, 8'h18, 1, 8'h10);
    tbl[9]  = mk(0, 1, 0, 8'h18, 1, 8'h10);
    tbl[10] = mk(1, 1, 1, 8'h18, 1, 8'h14);
    tbl[11] = mk(0, 1, 1, 8'h19, 1, 8'h14);
    tbl[12] = mk(0, 1, 1, 8'h1A, 1, 8'h14);
    tbl[13] = mk(0, 1, 1, 8'h1B, 1, 8'h14);
    tbl[14] = mk(0, 1, 0, 8'h1C, 1, 8'h14);
    tbl[15] = mk(1, 0, 1, 8'h1C, 1, 8'h18);

    // Reset state, zero-wait fetch, queue fill to IDLE, pop-restart.
    do_reset();
    chk_reset_outputs("reset");
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ready, tbl[i].ack, 1'b0, 8'h00);
      chk($sformatf("vec%0d req", i),   32'(bus.mem_req),     32'(tbl[i].e_req));
      chk($sformatf("vec%0d addr", i),  32'(bus.mem_addr),    32'(tbl[i].e_addr));
      chk($sformatf("vec%0d valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d pc", i),    32'(bus.instr_pc), 32'(tbl[i].e_pc));
        chk($sformatf("vec%0d instr", i), bus.instr,         tbl[i].e_instr);
      end
    end

    // Wait states: ack every third cycle, address must track completed beats only.
    do_reset();
    nacks = 0;
    cyc   = 0;
    while (!bus.instr_valid && cyc < 40) begin
      pre_req = bus.mem_req;
      ack     = (cyc % 3 == 2);
      step(1'b0, ack, 1'b0, 8'h00);
      if (pre_req && ack) nacks++;
      if (bus.mem_req && nacks < 4)
        chk($sformatf("wait addr c%0d", cyc), 32'(bus.mem_addr), 32'(8'h10 + 8'(nacks)));
      cyc++;
    end
    chk("wait valid", 32'(bus.instr_valid), 32'd1);
    chk("wait beats", 32'(nacks), 32'd4);
    chk("wait pc", 32'(bus.instr_pc), 32'h10);
    chk("wait instr", bus.instr, instr_at(8'h10));

    // Redirect during beat 2 with a concurrent ack, then a second redirect that wraps.
    do_reset();
    repeat (7) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre-redir addr", 32'(bus.mem_addr), 32'h16);
    step(1'b1, 1'b1, 1'b1, 8'hF0);
    chk("redir valid", 32'(bus.instr_valid), 32'd0);
    chk("redir req", 32'(bus.mem_req), 32'd1);
    chk("redir addr", 32'(bus.mem_addr), 32'hF0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("redir F0 valid", 32'(bus.instr_valid), 32'd1);
    chk("redir F0 pc", 32'(bus.instr_pc), 32'hF0);
    chk("redir F0 instr", bus.instr, instr_at(8'hF0));
    step(1'b1, 1'b1, 1'b1, 8'hFC);
    chk("redir2 valid", 32'(bus.instr_valid), 32'd0);
    chk("redir2 addr", 32'(bus.mem_addr), 32'hFC);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap FC pc", 32'(bus.instr_pc), 32'hFC);
    chk("wrap FC instr", bus.instr, instr_at(8'hFC));
    chk("wrap addr", 32'(bus.mem_addr), 32'h00);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap full req", 32'(bus.mem_req), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wrap 00 pc", 32'(bus.instr_pc), 32'h00);
    chk("wrap 00 instr", bus.instr, instr_at(8'h00));

    // Pop coinciding with a last-beat push keeps order; then async reset mid-fetch.
    do_reset();
    repeat (8) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    chk("pp valid", 32'(bus.instr_valid), 32'd1);
    chk("pp pc", 32'(bus.instr_pc), 32'h14);
    chk("pp instr", bus.instr, instr_at(8'h14));
    chk("pp req", 32'(bus.mem_req), 32'd1);
    chk("pp addr", 32'(bus.mem_addr), 32'h18);
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pp full req", 32'(bus.mem_req), 32'd0);
    chk("pp head kept", 32'(bus.instr_pc), 32'h14);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("pp second pc", 32'(bus.instr_pc), 32'h18);
    chk("pp second instr", bus.instr, instr_at(8'h18));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre-rst addr", 32'(bus.mem_addr), 32'h1D);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
